// File: rtl/czintc_pkg.sv
// Shared types and constants for the czintc interrupt controller.
// Width helpers keep the port declarations of every czintc file consistent.
package czintc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [1:0] CFG_MASK    = 2'd0;
    localparam logic [1:0] CFG_MODE    = 2'd1;
    localparam logic [1:0] CFG_PENDCLR = 2'd2;
    localparam logic [1:0] CFG_PENDSET = 2'd3;

    function automatic int id_width(input int n_irq);
        return (n_irq > 1) ? $clog2(n_irq) : 1;
    endfunction

    function automatic int depth_width(input int nest_depth);
        return $clog2(nest_depth + 1);
    endfunction

endpackage

// File: rtl/czintc_prio.sv
// Threshold priority encoder: lowest-index requesting channel strictly below cur.
// cur equal to N_IRQ lets every channel through.
module czintc_prio
    import czintc_pkg::*;
#(
    parameter int N_IRQ = 8
) (
    input  logic [N_IRQ-1:0]           req,
    input  logic [$clog2(N_IRQ+1)-1:0] cur,
    output logic                       vld,
    output logic [id_width(N_IRQ)-1:0] id
);

    localparam int IDW = id_width(N_IRQ);
    localparam int CW  = $clog2(N_IRQ + 1);

    // Scan from the top so the lowest eligible index is the last one written.
    always_comb begin
        vld = 1'b0;
        id  = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (req[i] && (CW'(i) < cur)) begin
                vld = 1'b1;
                id  = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/czintc.sv
// czintc: N-channel prioritised interrupt controller with a bounded nesting stack.
// Presents one vectored request to the core, handshaked by INTACK and unwound by RETURNI.
module czintc
    import czintc_pkg::*;
#(
    parameter int N_IRQ      = 8,
    parameter int PC_WIDTH   = 10,
    parameter int NEST_DEPTH = 4,
    parameter int VEC_BASE   = 2
) (
    input  logic                               CLK,
    input  logic                               xRESETN_P,
    input  logic [N_IRQ-1:0]                   xIRQ_P,
    input  logic                               xENABLE_P,
    input  logic                               xDISABLE_P,
    input  logic                               xINTACK_P,
    input  logic                               xRETI_P,
    input  logic                               xCFGWE_P,
    input  logic [1:0]                         xCFGA_P,
    input  logic [N_IRQ-1:0]                   xCFGD_P,
    output logic                               xINTREQ_P,
    output logic [PC_WIDTH-1:0]                xVEC_P,
    output logic [id_width(N_IRQ)-1:0]         xID_P,
    output logic [depth_width(NEST_DEPTH)-1:0] xNEST_P,
    output logic                               xGIE_P,
    output logic [N_IRQ-1:0]                   xPEND_P
);

    localparam int IDW = id_width(N_IRQ);
    localparam int DW  = depth_width(NEST_DEPTH);
    localparam int CW  = $clog2(N_IRQ + 1);

    logic [N_IRQ-1:0] s1, s2;
    logic [N_IRQ-1:0] mask, mode;
    logic [N_IRQ-1:0] pend, sw;
    logic [N_IRQ-1:0] pend_n, sw_n;
    logic [N_IRQ-1:0] edge_det, ack_clr, cfg_clr, cfg_set;

    state_t           state, state_n;
    logic [IDW-1:0]   stk_id  [NEST_DEPTH];
    logic             stk_gie [NEST_DEPTH];
    logic [DW-1:0]    depth;
    logic             gie;
    logic [IDW-1:0]   req_id;
    logic             intreq;
    logic [PC_WIDTH-1:0] vec;

    logic [CW-1:0]    cur;
    logic             top_gie;
    logic             win_vld;
    logic [IDW-1:0]   win_id;
    logic             raise, ack_fire, pop_fire;

    // Top of the in-service stack sets the preemption threshold.
    always_comb begin
        cur     = CW'(N_IRQ);
        top_gie = 1'b0;
        for (int i = 0; i < NEST_DEPTH; i++) begin
            if (DW'(i + 1) == depth) begin
                cur     = CW'(stk_id[i]);
                top_gie = stk_gie[i];
            end
        end
    end

    czintc_prio #(
        .N_IRQ (N_IRQ)
    ) u_prio (
        .req (pend & mask),
        .cur (cur),
        .vld (win_vld),
        .id  (win_id)
    );

    assign raise = gie && (depth < DW'(NEST_DEPTH)) && win_vld;

    always_comb begin
        state_n  = state;
        ack_fire = 1'b0;
        case (state)
            ST_IDLE: if (raise) state_n = ST_REQ;
            ST_REQ: begin
                if (xDISABLE_P) begin
                    state_n = ST_IDLE;
                end else if (xINTACK_P) begin
                    state_n  = ST_GAP;
                    ack_fire = 1'b1;
                end
            end
            ST_GAP:  state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    assign pop_fire = xRETI_P && !ack_fire && (depth != '0);

    // Pending: edge channels latch with set beating clear; level channels follow s1 or the sticky software bit.
    always_comb begin
        edge_det = s1 & ~s2;
        ack_clr  = ack_fire ? (N_IRQ'(1) << req_id) : '0;
        cfg_clr  = (xCFGWE_P && (xCFGA_P == CFG_PENDCLR)) ? xCFGD_P : '0;
        cfg_set  = (xCFGWE_P && (xCFGA_P == CFG_PENDSET)) ? xCFGD_P : '0;
        sw_n     = (sw & ~ack_clr & ~cfg_clr) | cfg_set;
        pend_n   = (mode & ((pend & ~ack_clr & ~cfg_clr) | edge_det | cfg_set))
                 | (~mode & (s1 | sw_n));
    end

    always_ff @(posedge CLK) begin
        if (!xRESETN_P) begin
            s1     <= '0;
            s2     <= '0;
            mask   <= '0;
            mode   <= '0;
            pend   <= '0;
            sw     <= '0;
            state  <= ST_IDLE;
            depth  <= '0;
            gie    <= 1'b0;
            req_id <= '0;
            intreq <= 1'b0;
            vec    <= '0;
            for (int i = 0; i < NEST_DEPTH; i++) begin
                stk_id[i]  <= '0;
                stk_gie[i] <= 1'b0;
            end
        end else begin
            s1    <= xIRQ_P;
            s2    <= s1;
            pend  <= pend_n;
            sw    <= sw_n;
            state <= state_n;
            if (xCFGWE_P && (xCFGA_P == CFG_MASK)) mask <= xCFGD_P;
            if (xCFGWE_P && (xCFGA_P == CFG_MODE)) mode <= xCFGD_P;

            if ((state == ST_IDLE) && raise) begin
                req_id <= win_id;
                vec    <= PC_WIDTH'(VEC_BASE) + PC_WIDTH'(win_id);
            end
            intreq <= (state_n == ST_REQ);

            if (ack_fire)        gie <= 1'b0;
            else if (xDISABLE_P) gie <= 1'b0;
            else if (xENABLE_P)  gie <= 1'b1;
            else if (pop_fire)   gie <= top_gie;

            if (ack_fire) begin
                for (int i = 0; i < NEST_DEPTH; i++) begin
                    if (DW'(i) == depth) begin
                        stk_id[i]  <= req_id;
                        stk_gie[i] <= gie;
                    end
                end
                depth <= depth + DW'(1);
            end else if (pop_fire) begin
                depth <= depth - DW'(1);
            end
        end
    end

    assign xINTREQ_P = intreq;
    assign xVEC_P    = vec;
    assign xID_P     = req_id;
    assign xNEST_P   = depth;
    assign xGIE_P    = gie;
    assign xPEND_P   = pend;

endmodule

// File: doc/czintc.md
# czintc

Parametrised interrupt controller for the cz core, replacing the fixed two-line INT0/INT1 sampling and enable logic in the core control block. It handles N_IRQ channels, each in edge or level mode with a per-channel mask and software-set pending. Priority is fixed, and a bounded in-service stack supports nested preemption. It presents one vectored request to the core through a req/ack handshake, and is popped by the core's RETURNI.

## Interface
- N_IRQ, 8: number of interrupt channels (2..32); channel 0 has the highest priority.
- PC_WIDTH, 10: program-counter width; sets the width of xVEC_P.
- NEST_DEPTH, 4: maximum number of in-service levels (1..8).
- VEC_BASE, 2: vector of channel 0; channel i vectors to VEC_BASE+i.

Ports:
- CLK  in  1  clock; all state changes on its rising edge.
- xRESETN_P  in  1  reset, synchronous, active-low.
- xIRQ_P  in  N_IRQ  raw interrupt lines, asynchronous to CLK.
- xENABLE_P  in  1  core executes ENABLE; sets GIE.
- xDISABLE_P  in  1  core executes DISABLE; clears GIE.
- xINTACK_P  in  1  core accepts the pending request; this is the interrupt-entry cycle.
- xRETI_P  in  1  core executes RETURNI; end of interrupt.
- xCFGWE_P  in  1  configuration write strobe.
- xCFGA_P  in  2  configuration address: 0 MASK, 1 MODE, 2 PENDCLR (write-1-to-clear), 3 PENDSET (write-1-to-set).
- xCFGD_P  in  N_IRQ  configuration write data.
- xINTREQ_P  out  1  interrupt request to the core.
- xVEC_P  out  PC_WIDTH  vector address; valid while xINTREQ_P is high.
- xID_P  out  $clog2(N_IRQ)  channel number of the request.
- xNEST_P  out  $clog2(NEST_DEPTH+1)  current in-service depth.
- xGIE_P  out  1  global interrupt enable.
- xPEND_P  out  N_IRQ  pending vector.

## Operation
- Synchroniser: xIRQ_P passes through two flops, s1 then s2. Edge detect is s1 & ~s2.
- MODE bit 1 means rising-edge mode. A detected edge latches the pending bit, which clears on ack of that channel or on a PENDCLR write. On the same cycle, set wins over clear.
- MODE bit 0 means level mode. The pending bit equals s1 OR the sticky software-set bit; ack clears only the software bit.
- An eligible channel is pending & MASK and has index < cur. cur is the channel on top of the in-service stack, or N_IRQ when the stack is empty.
- A request can be raised only when GIE=1 and the depth is below NEST_DEPTH. The lowest-index eligible channel wins.
- The FSM has three states: IDLE, REQ and GAP.
  - IDLE -> REQ when the request condition holds. The winning id is registered and xINTREQ_P=1.
  - REQ holds xINTREQ_P, xVEC_P and xID_P stable until xINTACK_P. Mask changes and higher-priority arrivals do not alter a held request.
  - REQ -> IDLE on xDISABLE_P, which withdraws the request; xINTACK_P in that same cycle is ignored.
  - REQ -> GAP on xINTACK_P. The controller pushes {id, GIE} onto the stack, clears GIE, and clears the edge-pending or software bit of that channel.
  - GAP -> IDLE unconditionally. This is one dead cycle that lets the core's entry sequence complete.
- xRETI_P pops the stack and restores GIE from the popped entry. xRETI_P with an empty stack is ignored.
- GIE: xDISABLE_P wins over xENABLE_P. Nesting requires the ISR to execute ENABLE.
- Simultaneous xINTACK_P and xRETI_P: the ack is processed and the RETI is ignored. The core never issues both.
- Configuration writes take effect on the next cycle. PENDSET on an edge-mode channel sets its pending latch.

## Timing
- Reset values for every output and state element: xINTREQ_P=0, xVEC_P=0, xID_P=0, xNEST_P=0, xGIE_P=0, xPEND_P=0; MASK=0, MODE=0, stack empty, FSM=IDLE, synchroniser flops 0.
- Reset has priority over every other input, including in the middle of the handshake.
- Latency: xIRQ_P rises before edge k, s1 captures it at edge k, pending is set at edge k+1, and xINTREQ_P goes high after edge k+2 (three edges in total when GIE=1 and the channel is unmasked).
- All outputs are registered, with no combinational path from inputs to outputs.
- After an ack at edge a, the earliest next request is after edge a+2.

## Structure
- Package czintc_pkg holds:
  - the FSM state enum (IDLE, REQ, GAP);
  - the configuration address constants (CFG_MASK=0, CFG_MODE=1, CFG_PENDCLR=2, CFG_PENDSET=3);
  - the ID width and depth width functions.
- Sub-module czintc_prio: a combinational threshold priority encoder. Inputs are the request vector and cur; outputs are a valid flag and the winning id.
- The stack is a register array of NEST_DEPTH entries, each {id, gie}, with a depth counter.

## Test plan
- Edge, basic request:
  - Stimulus: MASK=0xFF, MODE=0x08, ENABLE, then pulse xIRQ_P[3] for one cycle.
  - Response: xINTREQ_P after 3 edges with xVEC_P=5 and xID_P=3.
  - Then ack: xPEND_P[3]=0, xNEST_P=1, xGIE_P=0.
- Nested preemption:
  - Stimulus: inside the ch3 ISR, ENABLE, then raise ch1 (level).
  - Response: request with xVEC_P=3 and xNEST_P=2 after its ack.
  - Then raise ch5: no request is issued.
  - Two RETIs: depth 0, GIE=1.
- Stack full:
  - Stimulus: NEST_DEPTH=4; nest channels 6, 4, 2, 0 with ENABLE in each ISR.
  - Response: any further pending channel gets no request until a RETI.
- Level re-request:
  - Stimulus: ch2 level mode held high through ack and RETI.
  - Response: the request re-asserts 1 cycle after the RETI pop, provided GIE was restored to 1.
- Withdraw and simultaneous events:
  - Stimulus: xDISABLE_P asserted while in REQ.
  - Response: xINTREQ_P=0 next cycle and the pending bit is kept.
  - Stimulus: PENDCLR and a new edge on the same channel in the same cycle.
  - Response: pending stays 1.
- Reset in the middle of the handshake:
  - Stimulus: xRESETN_P=0 while in REQ with xNEST_P=2.
  - Response: all outputs are 0 on the next edge, and the stack and MASK are cleared.
